// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, types, data-bit position table and encoder for Hamming(21,16)
package hamming_pkg;
  localparam int DATA_W = 16;
  localparam int PAR_W = 5;
  localparam int CODE_W = DATA_W + PAR_W;
  localparam int CNT_W = 16;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [PAR_W-1:0] syndrome_t;
  typedef logic [DATA_W-1:0] data_t;
  localparam logic [4:0] DATA_POS [DATA_W] = '{5'd2, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11,
                                               5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
  function automatic code_t hamming_encode(input data_t d);
    code_t c = '0;
    syndrome_t s = '0;
    for (int i = 0; i < DATA_W; i++) c[DATA_POS[i]] = d[i];
    for (int i = 0; i < CODE_W; i++) s ^= c[i] ? syndrome_t'(i + 1) : '0;
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
    c[7] = s[3];
    c[15] = s[4];
    return c;
  endfunction
endpackage

// File: rtl/hamming_syndrome_calc.sv
// hamming_syndrome_calc: combinational syndrome, XOR of (i+1) over every set code bit
module hamming_syndrome_calc
  import hamming_pkg::*;
(
  input  code_t     code,
  output syndrome_t syndrome
);
  // fold the positions of all set bits together
  always_comb begin
    syndrome = '0;
    for (int i = 0; i < CODE_W; i++) syndrome ^= code[i] ? syndrome_t'(i + 1) : '0;
  end
endmodule

// File: rtl/hamming_stream_decoder.sv
// hamming_stream_decoder: 2-stage valid/ready Hamming(21,16) decoder; HAMMING_ERR_CNT_EN adds error counters
module hamming_stream_decoder
  import hamming_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  code_t     in_code,
  output logic      out_valid,
  input  logic      out_ready,
  output data_t     out_data,
  output syndrome_t out_syndrome,
  output logic      out_corrected,
  output logic      out_uncorrectable
`ifdef HAMMING_ERR_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
`endif
);
  logic s1_valid, s2_ready, corr, uncorr;
  code_t s1_code, fix;
  syndrome_t syn, s1_syn;
  data_t data;
  hamming_syndrome_calc u_syn (.code(in_code), .syndrome(syn));
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  // S1: capture codeword and its syndrome whenever the stage can move
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code <= '0;
      s1_syn <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      s1_code <= in_code;
      s1_syn <= syn;
    end
  // flip the bit the syndrome points at, then gather the data positions
  always_comb begin
    corr = s1_syn != '0 && s1_syn <= syndrome_t'(CODE_W);
    uncorr = s1_syn > syndrome_t'(CODE_W);
    fix = s1_code ^ (corr ? code_t'(1) << (s1_syn - 1'b1) : '0);
    data = '0;
    for (int i = 0; i < DATA_W; i++) data[i] = fix[DATA_POS[i]];
  end
  // S2: output register, held while downstream stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_syndrome <= '0;
      out_corrected <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      out_data <= data;
      out_syndrome <= s1_syn;
      out_corrected <= corr;
      out_uncorrectable <= uncorr;
    end
`ifdef HAMMING_ERR_CNT_EN
  // saturating statistics on delivered words; clear wins over increment
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      corr_cnt <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= '0;
      uncorr_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_corrected && !(&corr_cnt)) corr_cnt <= corr_cnt + 1'b1;
      if (out_uncorrectable && !(&uncorr_cnt)) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_hamming_stream_decoder.sv
// tb_hamming_stream_decoder: scoreboard bench with directed and random streams; HAMMING_ERR_CNT_EN checks counters
module tb_hamming_stream_decoder;
  import hamming_pkg::*;
  typedef struct packed {logic [15:0] d; logic [4:0] s; logic c; logic u;} exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_corrected, out_uncorrectable;
  code_t in_code = '0;
  logic [15:0] out_data;
  logic [4:0] out_syndrome;
`ifdef HAMMING_ERR_CNT_EN
  logic cnt_clr = 0;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
`endif
  int tests = 0, fails = 0, cyc = 0;
  exp_t exp_q[$];
  int cyc_q[$];
  bit chk_lat = 0, hold_v = 0, done = 0;
  exp_t held;

  hamming_stream_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable)
`ifdef HAMMING_ERR_CNT_EN
    , .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  function automatic exp_t model(input code_t code);
    exp_t e;
    int s = 0, k = 0;
    code_t c = code;
    for (int p = 1; p <= 21; p++) if (c[p-1]) s ^= p;
    if (s >= 1 && s <= 21) c[s-1] = ~c[s-1];
    e.d = '0;
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin
        e.d[k] = c[p-1];
        k++;
      end
    e.s = s[4:0];
    e.c = s >= 1 && s <= 21;
    e.u = s > 21;
    return e;
  endfunction

  task automatic send(input code_t c, input exp_t e);
    in_valid = 1;
    in_code = c;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n == 300) begin
        chk("in_ready_timeout", in_ready, 1);
        break;
      end
    end
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && exp_q.size() > 0; n++) @(posedge clk);
    chk("drain_left", exp_q.size(), 0);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int c0;
    if (out_valid && hold_v)
      chk("hold_stable", {out_data, out_syndrome, out_corrected, out_uncorrectable}, held);
    hold_v = out_valid && !out_ready;
    held = {out_data, out_syndrome, out_corrected, out_uncorrectable};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_word", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        c0 = cyc_q.pop_front();
        chk("data", out_data, e.d);
        chk("syndrome", out_syndrome, e.s);
        chk("corrected", out_corrected, e.c);
        chk("uncorrectable", out_uncorrectable, e.u);
        if (chk_lat) chk("latency", cyc - c0, 2);
      end
    end
  end

  initial begin
    code_t c;
    logic [15:0] d;
    int b1, b2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_syndrome", out_syndrome, 0);
    chk("rst_flags", {out_corrected, out_uncorrectable}, 0);
    rst = 0;
    chk("in_ready_after_rst", in_ready, 1);
    chk_lat = 1;
    send(hamming_encode(16'hA5A5), exp_t'{16'hA5A5, 5'd0, 1'b0, 1'b0});
    send(hamming_encode(16'h0000), exp_t'{16'h0000, 5'd0, 1'b0, 1'b0});
    send(hamming_encode(16'hFFFF), exp_t'{16'hFFFF, 5'd0, 1'b0, 1'b0});
    send(hamming_encode(16'h1234) ^ (code_t'(1) << 10), exp_t'{16'h1234, 5'd11, 1'b1, 1'b0});
    send(hamming_encode(16'hBEEF) ^ (code_t'(1) << 15), exp_t'{16'hBEEF, 5'd16, 1'b1, 1'b0});
    c = hamming_encode(16'h0F0F) ^ (code_t'(1) << 20) ^ (code_t'(1) << 1);
    send(c, exp_t'{model(c).d, 5'd23, 1'b0, 1'b1});
    drain();
    chk_lat = 0;
    out_ready = 0;
    fork
      for (int i = 0; i < 4; i++) begin
        d = 16'($urandom);
        send(hamming_encode(d), exp_t'{d, 5'd0, 1'b0, 1'b0});
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    send(hamming_encode(16'h1111), exp_t'{16'h1111, 5'd0, 1'b0, 1'b0});
    send(hamming_encode(16'h2222), exp_t'{16'h2222, 5'd0, 1'b0, 1'b0});
    chk("pre_rst_out_valid", out_valid, 1);
    #2 rst = 1;
    #1 chk("async_rst_out_valid", out_valid, 0);
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    rst = 0;
    chk("in_ready_after_midrst", in_ready, 1);
    out_ready = 1;
    @(posedge clk);
    #1;
`ifdef HAMMING_ERR_CNT_EN
    chk("corr_cnt_rst", corr_cnt, 0);
    chk("uncorr_cnt_rst", uncorr_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      c = hamming_encode(16'($urandom)) ^ (code_t'(1) << $urandom_range(0, 20));
      send(c, model(c));
    end
    c = hamming_encode(16'h0F0F) ^ (code_t'(1) << 20) ^ (code_t'(1) << 1);
    send(c, model(c));
    drain();
    chk("corr_cnt_3", corr_cnt, 3);
    chk("uncorr_cnt_1", uncorr_cnt, 1);
    cnt_clr = 1;
    @(posedge clk);
    #1 cnt_clr = 0;
    chk("corr_cnt_clr", corr_cnt, 0);
    chk("uncorr_cnt_clr", uncorr_cnt, 0);
`endif
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          c = hamming_encode(16'($urandom));
          b1 = $urandom_range(0, 20);
          b2 = (b1 + 1 + $urandom_range(0, 19)) % 21;
          case ($urandom_range(0, 2))
            1: c ^= code_t'(1) << b1;
            2: c ^= (code_t'(1) << b1) ^ (code_t'(1) << b2);
            default: ;
          endcase
          send(c, model(c));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
